// File: rtl/kypd_scan_nexys_a7.sv
// Pmod KYPD 4x4 matrix scanner with frame-based debounce.
// Emits a hex key code, a press strobe and a display-ready digit word.
module kypd_scan_nexys_a7 #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [5:0] key_dig
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    logic [3:0]       row_m_q;
    logic [3:0]       row_s_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       slot_q;
    logic [1:0]       slot_d;
    logic [3:0]       col_q;
    logic [3:0]       col_d;
    logic [11:0]      smp_q;
    logic [11:0]      smp_d;
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [3:0]       cand_q;
    logic [3:0]       cand_d;
    logic [3:0]       code_q;
    logic [3:0]       code_d;
    logic             valid_q;
    logic             valid_d;
    logic             held_q;
    logic             held_d;
    logic             have_q;
    logic             have_d;
    logic [5:0]       dig_q;
    logic [5:0]       dig_d;

    logic             tick;
    logic             frame_end;
    logic [15:0]      lows;
    logic [4:0]       n_low;
    logic [3:0]       low_pos;
    logic             f_none;
    logic             f_single;
    logic [3:0]       f_key;
    logic             accept;
    logic             rel;

    // Position is {column, row}; map to the printed legend.
    function automatic logic [3:0] pos2hex(input logic [3:0] pos);
        logic [3:0] h;
        unique case (pos)
            4'h0: h = 4'h1;
            4'h1: h = 4'h4;
            4'h2: h = 4'h7;
            4'h3: h = 4'h0;
            4'h4: h = 4'h2;
            4'h5: h = 4'h5;
            4'h6: h = 4'h8;
            4'h7: h = 4'hF;
            4'h8: h = 4'h3;
            4'h9: h = 4'h6;
            4'hA: h = 4'h9;
            4'hB: h = 4'hE;
            4'hC: h = 4'hA;
            4'hD: h = 4'hB;
            4'hE: h = 4'hC;
            4'hF: h = 4'hD;
            default: h = 4'h0;
        endcase
        return h;
    endfunction

    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (slot_q == 2'd3);

    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        slot_d = tick ? slot_q + 2'd1 : slot_q;
        col_d  = ~(4'b0001 << slot_d);
    end

    always_comb begin
        smp_d = smp_q;
        if (tick) begin
            unique case (slot_q)
                2'd0: smp_d[3:0]  = ~row_s_q;
                2'd1: smp_d[7:4]  = ~row_s_q;
                2'd2: smp_d[11:8] = ~row_s_q;
                default: smp_d = smp_q;
            endcase
        end
    end

    // Column 3 is classified straight from the synchroniser at its tick.
    assign lows = {~row_s_q, smp_q};

    always_comb begin
        n_low   = '0;
        low_pos = '0;
        for (int i = 0; i < 16; i++) begin
            n_low = n_low + {4'd0, lows[i]};
            if (lows[i]) begin
                low_pos = 4'(i);
            end
        end
        f_none   = (n_low == 5'd0);
        f_single = (n_low == 5'd1);
        f_key    = pos2hex(low_pos);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        rel     = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (f_single) begin
                        cand_d = f_key;
                        if (DEB_N <= 4'd1) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (f_single && f_key == cand_q) begin
                        if (cnt_q + 4'd1 >= DEB_N) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (f_single) begin
                        cand_d = f_key;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (f_none) begin
                        if (DEB_N <= 4'd1) begin
                            rel     = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = REL_CHK;
                        end
                    end
                end
                REL_CHK: begin
                    if (f_none) begin
                        if (cnt_q + 4'd1 >= DEB_N) begin
                            rel     = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = accept;
        code_d  = accept ? cand_d : code_q;
        have_d  = have_q | accept;
        held_d  = held_q;
        if (accept) begin
            held_d = 1'b1;
        end else if (rel) begin
            held_d = 1'b0;
        end
        dig_d = {have_d, code_d, held_d};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_m_q <= 4'hF;
            row_s_q <= 4'hF;
            div_q   <= '0;
            slot_q  <= '0;
            col_q   <= 4'hF;
            smp_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            have_q  <= 1'b0;
            dig_q   <= '0;
        end else begin
            row_m_q <= row;
            row_s_q <= row_m_q;
            div_q   <= div_d;
            slot_q  <= slot_d;
            col_q   <= col_d;
            smp_q   <= smp_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            have_q  <= have_d;
            dig_q   <= dig_d;
        end
    end

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign key_dig   = dig_q;

endmodule

// File: tb/tb_kypd_scan_nexys_a7.sv
// Randomised keypad bench for kypd_scan_nexys_a7 with a frame-level
// reference model of the debounce rules.
module tb_kypd_scan_nexys_a7;

    localparam int SD = 4;
    localparam int DF = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [5:0] key_dig;

    logic [15:0] press = '0;
    int          nvec  = 0;
    int          nerr  = 0;
    int          cyc   = 0;

    // Keys indexed by r*4+c.
    logic [3:0] keymap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    bit         m_held;
    bit         m_have;
    int         m_run;
    logic [3:0] m_cand;
    logic [3:0] m_code;

    kypd_scan_nexys_a7 #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .key_dig  (key_dig)
    );

    always #5 clock = ~clock;

    // Passive keypad: a pressed key shorts its row to its driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && press[r*4+c]) row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_held = 0;
        m_have = 0;
        m_run  = 0;
        m_cand = '0;
        m_code = '0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_col", {4'd0, col}, 8'h0F);
        chk("rst_code", {4'd0, key_code}, 8'h00);
        chk("rst_valid", {7'd0, key_valid}, 8'h00);
        chk("rst_held", {7'd0, key_held}, 8'h00);
        chk("rst_dig", {2'd0, key_dig}, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
        model_clear();
    endtask

    // One whole frame of stable keys; returns whether a press is accepted.
    task automatic model_frame(input logic [15:0] p, output bit acc);
        int         n;
        logic [3:0] k;
        n   = $countones(p);
        k   = '0;
        acc = 0;
        for (int i = 0; i < 16; i++) if (p[i]) k = keymap[i];
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_cand) m_run++;
                else begin
                    m_cand = k;
                    m_run  = 1;
                end
                if (m_run >= DF) begin
                    acc    = 1;
                    m_held = 1;
                    m_have = 1;
                    m_code = k;
                    m_run  = 0;
                end
            end else m_run = 0;
        end else begin
            if (n == 0) begin
                m_run++;
                if (m_run >= DF) begin
                    m_held = 0;
                    m_run  = 0;
                end
            end else m_run = 0;
        end
    endtask

    task automatic frame(input logic [15:0] p);
        bit         acc;
        logic [3:0] ecol;
        logic [5:0] edig;
        model_frame(p, acc);
        press = p;
        for (int i = 0; i < 4 * SD; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            ecol = ~(4'b0001 << ((cyc / SD) % 4));
            chk("col", {4'd0, col}, {4'd0, ecol});
            chk("valid", {7'd0, key_valid},
                {7'd0, (i == 4 * SD - 1) && acc});
        end
        edig = {m_have, m_code, m_held};
        chk("code", {4'd0, key_code}, {4'd0, m_code});
        chk("held", {7'd0, key_held}, {7'd0, m_held});
        chk("dig", {2'd0, key_dig}, {2'd0, edig});
    endtask

    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K2 = 16'h0002;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K7 = 16'h0100;
    localparam logic [15:0] KF = 16'h2000;
    localparam logic [15:0] KD = 16'h8000;

    initial begin
        logic [15:0] cur;
        int          mode;
        int          a;
        int          b;
        model_clear();
        #2;
        do_reset();

        repeat (2) frame('0);

        repeat (5) frame(K5);
        chk("dig_k5", {2'd0, key_dig}, 8'h2B);

        repeat (2) frame('0);
        frame(K5);
        repeat (3) frame('0);
        chk("dig_rel", {2'd0, key_dig}, 8'h2A);

        repeat (2) frame(KD);
        frame('0);
        repeat (3) frame(KD);
        chk("code_d", {4'd0, key_code}, 8'h0D);
        repeat (3) frame('0);

        repeat (6) frame(K1 | K2);
        repeat (3) frame(K7);
        repeat (2) frame(KF);
        chk("code_7", {4'd0, key_code}, 8'h07);
        repeat (3) frame('0);

        repeat (2) frame(K5);
        repeat (5) @(posedge clock);
        #1;
        do_reset();
        repeat (3) frame(K5);
        repeat (3) frame('0);

        cur = '0;
        for (int f = 0; f < 80; f++) begin
            mode = $urandom_range(0, 9);
            if (mode >= 4 && mode <= 5) cur = '0;
            else if (mode >= 6 && mode <= 8)
                cur = 16'(1) << $urandom_range(0, 15);
            else if (mode == 9) begin
                a   = $urandom_range(0, 15);
                b   = (a + $urandom_range(1, 15)) % 16;
                cur = (16'(1) << a) | (16'(1) << b);
            end
            frame(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/kypd_scan_nexys_a7.md
Name: kypd_scan_nexys_a7

Overview:
Input-side counterpart of the 8-digit display driver. It scans a 4x4 Pmod KYPD matrix by driving one column low at a time and reading the four active-low rows. Each press is debounced and reported as a 4-bit hex code with a one-cycle valid strobe. A 6-bit digit word in the display driver's {enable, hex[3:0], dp} format is also produced, so a key can be routed straight to any d1..d8 input.

Parameters:
SCAN_DIV, 100000, clocks per column slot (1 ms at 100 MHz); must be >= 4.
DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or a release; range 1..15.

Ports:
clock  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-high.
row  in  4  keypad rows, active-low, externally pulled up; row[0] is the top row.
col  out  4  keypad columns, active-low drive, one low at a time; col[0] is the leftmost column.
key_code  out  4  hex value of the last accepted key.
key_valid  out  1  one-clock pulse when a press is accepted.
key_held  out  1  high from press acceptance until release acceptance.
key_dig  out  6  {have_key, key_code, key_held}: bit5 is the display enable, bit0 is the dp (lit while held).

Behaviour:
- Clocking and reset:
  - reset is asynchronous, active-high; clock is the single clock. No derived clocks; the prescaler produces a one-cycle tick every SCAN_DIV clocks.
  - Reset values: col=4'b1111, key_code=0, key_valid=0, key_held=0, key_dig=6'b000000, have_key=0, FSM=IDLE, all counters 0.
  - Reset asserted mid-operation aborts any scan or debounce immediately; no key_valid pulse is emitted for a partially debounced key.
- Row synchronisation: row passes through a 2-FF synchroniser before any use.
- Scan sequence:
  - After reset, slot index s=0 and col = ~(1<<s), so col0 is driven first.
  - At each tick, the synchronised row is sampled for column s, then s advances 0->1->2->3->0 and col updates on the same edge.
  - Sampling at slot end gives SCAN_DIV-2 clocks of settling.
- Key map (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame classification: a frame is the 4 samples ending at the tick that samples col3. It is classified as:
  - NONE: no low row bits.
  - SINGLE(K): exactly one low bit in exactly one column.
  - MULTI: anything else.
- Debounce FSM, evaluated once per frame end; cnt counts matching frames:
  - IDLE:
    - SINGLE(K) -> PRESS_CHK, with cand=K, cnt=1.
    - If DEBOUNCE_FRAMES=1, go directly to HELD with acceptance.
    - Otherwise stay.
  - PRESS_CHK:
    - SINGLE(cand) -> cnt+1; on reaching DEBOUNCE_FRAMES -> HELD with acceptance.
    - SINGLE(other K) -> restart with cand=K, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - NONE -> REL_CHK, cnt=1.
    - SINGLE(key_code) -> stay.
    - SINGLE(other) or MULTI -> stay (rollover ignored; no new event).
  - REL_CHK:
    - NONE -> cnt+1; on reaching DEBOUNCE_FRAMES -> IDLE, key_held=0.
    - Any other class -> HELD.
- Acceptance: on the clock after the accepting frame-end tick, key_code=cand, key_held=1, have_key=1, and key_valid=1 for exactly one clock. have_key stays sticky until reset.
- Press latency: key_valid asserts DEBOUNCE_FRAMES*4*SCAN_DIV clocks (+/- one frame of phase) after a stable press begins. This is 16 ms at default settings.
- key_dig is registered and always equals {have_key, key_code, key_held}.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 (frame = 16 clocks) for all scenarios.
1. Reset, rows all 1 -> col cycles 1110, 1101, 1011, 0111, each for 4 clocks; key_valid never pulses; key_dig=000000.
2. Model a press of key 5 (row1 low only while col=1101), held for 5 frames -> exactly one key_valid pulse after the 3rd matching frame; key_code=5; key_held=1; key_dig=6'b101011.
3. Release after 2, then bounce 1 frame pressed, then release for 3 frames -> key_held stays 1 through the bounce; it drops after the 3rd consecutive NONE frame; key_dig=6'b101010; no extra key_valid.
4. Bouncy press of key D (row3/col3 present 2 frames, absent 1, present 3) -> a single key_valid occurs only after the final 3 consecutive frames; key_code=4'hD.
5. Keys 1 and 2 pressed together for 6 frames -> MULTI; no key_valid; state remains IDLE. Then hold F alone during HELD of 7 -> no new pulse, and key_code stays 7.
6. Assert reset while in PRESS_CHK with cnt=2 -> all outputs return to their reset values immediately; after release, the press is re-debounced from cnt=0.
